// File: rtl/kf8259_bus_pkg.sv
// Shared types and constants for the KF8259 bus initiator: bus-cycle phases,
// init steps and the A0 encodings used on the PIC port.
package kf8259_bus_pkg;

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_SETUP,
    PH_STROBE,
    PH_RECOVER
  } phase_e;

  typedef enum logic [2:0] {
    STEP_NONE,
    STEP_ICW1,
    STEP_ICW2,
    STEP_ICW3,
    STEP_ICW4,
    STEP_OCW1
  } step_e;

  localparam logic A0_CMD        = 1'b0;
  localparam logic A0_DATA       = 1'b1;
  localparam int   ICW1_MARK_BIT = 4;

  // The PIC recognises ICW1 by bit 4, so it is always set on the bus.
  function automatic logic [7:0] mark_icw1(input logic [7:0] value);
    logic [7:0] marked;
    marked                = value;
    marked[ICW1_MARK_BIT] = 1'b1;
    return marked;
  endfunction

endpackage

// File: rtl/kf8259_bus_cycle.sv
// Single-access engine for the PIC port: SETUP -> STROBE (until ack or
// timeout) -> RECOVER, with read-data capture and a registered bus.
module kf8259_bus_cycle
  import kf8259_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       req_i,
  input  logic       req_read_i,
  input  logic       req_addr_i,
  input  logic [7:0] req_data_i,
  output phase_e     phase_o,
  output logic       done_o,
  output logic       timeout_o,
  output logic       rsp_valid_o,
  output logic [7:0] rsp_data_o,
  output logic       cs_o,
  output logic       rd_o,
  output logic       wr_o,
  output logic       addr_o,
  output logic [7:0] dout_o,
  input  logic [7:0] din_i,
  input  logic       ack_i
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  phase_e        phase_q;
  logic          read_q;
  logic [CW-1:0] cnt_q;
  logic          cs_q, rd_q, wr_q, addr_q;
  logic [7:0]    dout_q;
  logic          done_q, timeout_q, rsp_valid_q;
  logic [7:0]    rsp_data_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      phase_q     <= PH_IDLE;
      read_q      <= 1'b0;
      cnt_q       <= '0;
      cs_q        <= 1'b0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      addr_q      <= 1'b0;
      dout_q      <= 8'h00;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 8'h00;
    end else begin
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      case (phase_q)
        // RECOVER accepts a new request directly so init steps run gap-free.
        PH_IDLE, PH_RECOVER: begin
          if (req_i) begin
            phase_q <= PH_SETUP;
            read_q  <= req_read_i;
            cs_q    <= 1'b1;
            addr_q  <= req_addr_i;
            dout_q  <= req_read_i ? 8'h00 : req_data_i;
            cnt_q   <= '0;
          end else begin
            phase_q <= PH_IDLE;
          end
        end
        PH_SETUP: begin
          phase_q <= PH_STROBE;
          rd_q    <= read_q;
          wr_q    <= !read_q;
        end
        PH_STROBE: begin
          if (ack_i || cnt_q == CNT_LAST) begin
            phase_q <= PH_RECOVER;
            cs_q    <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= 1'b0;
            dout_q  <= 8'h00;
          end
          // ack takes priority over a timeout firing in the same cycle.
          if (ack_i) begin
            done_q <= 1'b1;
            if (read_q) begin
              rsp_data_q  <= din_i;
              rsp_valid_q <= 1'b1;
            end
          end else if (cnt_q == CNT_LAST) begin
            timeout_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: phase_q <= PH_IDLE;
      endcase
    end
  end

  assign phase_o     = phase_q;
  assign done_o      = done_q;
  assign timeout_o   = timeout_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign cs_o        = cs_q;
  assign rd_o        = rd_q;
  assign wr_o        = wr_q;
  assign addr_o      = addr_q;
  assign dout_o      = dout_q;

endmodule

// File: rtl/kf8259_init_sequencer.sv
// KF8259 programming initiator: runs ICW1..ICW4 + OCW1 after start, then
// forwards single host reads/writes to the PIC through kf8259_bus_cycle.
module kf8259_init_sequencer
  import kf8259_bus_pkg::*;
#(
  parameter logic [7:0]  ICW1    = 8'h13,
  parameter logic [7:0]  ICW2    = 8'h08,
  parameter logic [7:0]  ICW3    = 8'h00,
  parameter logic [7:0]  ICW4    = 8'h01,
  parameter logic [7:0]  OCW1    = 8'hFF,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  input  logic       cmd_read_i,
  input  logic       cmd_address_i,
  input  logic [7:0] cmd_data_i,
  output logic       rsp_valid_o,
  output logic [7:0] rsp_data_o,
  output logic       chip_select_o,
  output logic       read_enable_o,
  output logic       write_enable_o,
  output logic       address_o,
  output logic [7:0] data_bus_out_o,
  input  logic [7:0] data_bus_in_i,
  input  logic       ack_i,
  output logic       busy_o,
  output logic       init_done_o,
  output logic       error_o
);

  step_e      step_q, step_d;
  logic       init_done_q, init_done_d;
  logic       error_q, error_d;
  phase_e     phase;
  logic       acc_done, acc_timeout;
  logic       req, req_read, req_addr;
  logic [7:0] req_data;
  logic       bus_idle, start_ok, cmd_fire;

  // ICW3 only exists for cascaded setups (SNGL = 0), ICW4 only when IC4 = 1.
  function automatic step_e next_step(input step_e s);
    case (s)
      STEP_ICW1: return STEP_ICW2;
      STEP_ICW2: return !ICW1[1] ? STEP_ICW3 : (ICW1[0] ? STEP_ICW4 : STEP_OCW1);
      STEP_ICW3: return ICW1[0] ? STEP_ICW4 : STEP_OCW1;
      STEP_ICW4: return STEP_OCW1;
      default:   return STEP_NONE;
    endcase
  endfunction

  function automatic logic [7:0] step_word(input step_e s);
    case (s)
      STEP_ICW1: return mark_icw1(ICW1);
      STEP_ICW2: return ICW2;
      STEP_ICW3: return ICW3;
      STEP_ICW4: return ICW4;
      default:   return OCW1;
    endcase
  endfunction

  assign bus_idle    = (phase == PH_IDLE) && (step_q == STEP_NONE);
  assign start_ok    = start_i && bus_idle;
  assign cmd_ready_o = bus_idle && init_done_q && !start_i;
  assign cmd_fire    = cmd_valid_i && cmd_ready_o;

  always_comb begin
    step_d      = step_q;
    init_done_d = init_done_q;
    error_d     = error_q;
    req         = 1'b0;
    req_read    = 1'b0;
    req_addr    = A0_CMD;
    req_data    = 8'h00;
    if (start_ok) begin
      step_d      = STEP_ICW1;
      init_done_d = 1'b0;
      error_d     = 1'b0;
      req         = 1'b1;
      req_addr    = A0_CMD;
      req_data    = step_word(STEP_ICW1);
    end else if (cmd_fire) begin
      req      = 1'b1;
      req_read = cmd_read_i;
      req_addr = cmd_address_i;
      req_data = cmd_data_i;
    end else if (acc_timeout) begin
      step_d  = STEP_NONE;
      error_d = 1'b1;
    end else if (acc_done && step_q != STEP_NONE) begin
      step_d = next_step(step_q);
      if (step_q == STEP_OCW1) begin
        init_done_d = 1'b1;
      end else begin
        req      = 1'b1;
        req_addr = A0_DATA;
        req_data = step_word(next_step(step_q));
      end
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      step_q      <= STEP_NONE;
      init_done_q <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      step_q      <= step_d;
      init_done_q <= init_done_d;
      error_q     <= error_d;
    end
  end

  kf8259_bus_cycle #(
    .TIMEOUT(TIMEOUT)
  ) u_bus_cycle (
    .clk_i      (clock_i),
    .rst_i      (reset_i),
    .req_i      (req),
    .req_read_i (req_read),
    .req_addr_i (req_addr),
    .req_data_i (req_data),
    .phase_o    (phase),
    .done_o     (acc_done),
    .timeout_o  (acc_timeout),
    .rsp_valid_o(rsp_valid_o),
    .rsp_data_o (rsp_data_o),
    .cs_o       (chip_select_o),
    .rd_o       (read_enable_o),
    .wr_o       (write_enable_o),
    .addr_o     (address_o),
    .dout_o     (data_bus_out_o),
    .din_i      (data_bus_in_i),
    .ack_i      (ack_i)
  );

  assign busy_o      = (phase != PH_IDLE) || (step_q != STEP_NONE);
  assign init_done_o = init_done_q;
  assign error_o     = error_q;

endmodule

// File: tb/tb_kf8259_init_sequencer.sv
// Directed bench for kf8259_init_sequencer: default and cascade init, host
// commands, wait states, timeout boundaries and asynchronous reset.
module tb_kf8259_init_sequencer;

  logic clk = 1'b0;
  initial forever #5 clk = ~clk;

  logic rst = 1'b1;

  logic       start0 = 1'b0, cmd_valid = 1'b0, cmd_read = 1'b0, cmd_addr = 1'b0;
  logic [7:0] cmd_data = 8'h00;
  logic       cmd_ready, rsp_valid;
  logic [7:0] rsp_data;
  logic       cs0, re0, we0, a0;
  logic [7:0] dout0, din0;
  logic       busy0, done0, err0;
  logic       ack_q = 1'b0;
  logic [7:0] pic_rd = 8'h5A;

  logic       start1 = 1'b0;
  logic       cmd_ready1, rsp_valid1;
  logic [7:0] rsp_data1;
  logic       cs1, re1, we1, a1, ack1;
  logic [7:0] dout1;
  logic       busy1, done1, err1;

  int n_chk = 0;
  int n_fail = 0;

  int  stall_cnt = 0, wr_cnt = 0, stall_idx = -1, stall_need = 0, need = 0;
  bit  ack_en = 1'b1, unstable = 1'b0;
  logic       s_addr = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic [8:0] wlog0[$];
  int         wlen0[$];
  logic [8:0] wlog1[$];

  logic [8:0] exp_def [4] = '{9'h013, 9'h108, 9'h101, 9'h1FF};
  logic [8:0] exp_cas [5] = '{9'h011, 9'h108, 9'h100, 9'h101, 9'h1FF};

  assign din0 = re0 ? pic_rd : 8'h00;
  assign ack1 = cs1 && (re1 || we1);

  kf8259_init_sequencer u_dut (
    .clock_i(clk), .reset_i(rst), .start_i(start0),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_read_i(cmd_read),
    .cmd_address_i(cmd_addr), .cmd_data_i(cmd_data),
    .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data),
    .chip_select_o(cs0), .read_enable_o(re0), .write_enable_o(we0),
    .address_o(a0), .data_bus_out_o(dout0), .data_bus_in_i(din0), .ack_i(ack_q),
    .busy_o(busy0), .init_done_o(done0), .error_o(err0)
  );

  kf8259_init_sequencer #(.ICW1(8'h11)) u_casc (
    .clock_i(clk), .reset_i(rst), .start_i(start1),
    .cmd_valid_i(1'b0), .cmd_ready_o(cmd_ready1), .cmd_read_i(1'b0),
    .cmd_address_i(1'b0), .cmd_data_i(8'h00),
    .rsp_valid_o(rsp_valid1), .rsp_data_o(rsp_data1),
    .chip_select_o(cs1), .read_enable_o(re1), .write_enable_o(we1),
    .address_o(a1), .data_bus_out_o(dout1), .data_bus_in_i(8'h00), .ack_i(ack1),
    .busy_o(busy1), .init_done_o(done1), .error_o(err1)
  );

  // PIC responder: ack after stall_need wait cycles on write number stall_idx.
  always @(negedge clk) begin
    need = (we0 && wr_cnt == stall_idx) ? stall_need : 0;
    if (cs0 && (re0 || we0)) begin
      stall_cnt = stall_cnt + 1;
      if (a0 !== s_addr || dout0 !== s_data) unstable = 1'b1;
      ack_q = ack_en && (stall_cnt > need);
      if (ack_q && we0) begin
        wlog0.push_back({a0, dout0});
        wlen0.push_back(stall_cnt);
        wr_cnt = wr_cnt + 1;
      end
    end else begin
      stall_cnt = 0;
      ack_q     = 1'b0;
      if (cs0) begin
        s_addr = a0;
        s_data = dout0;
      end
    end
  end

  always @(negedge clk) if (cs1 && we1) wlog1.push_back({a1, dout1});

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_log();
    wlog0.delete();
    wlen0.delete();
    wr_cnt = 0;
  endtask

  task automatic test_reset();
    repeat (2) step();
    n_chk++; if ({cs0, re0, we0, a0, dout0, rsp_valid, rsp_data, busy0, done0, err0, cmd_ready} !== 25'd0) begin
      n_fail++; $display("FAIL reset_outputs_dut0: got %h want 0", {cs0, re0, we0, a0, dout0, rsp_valid, rsp_data, busy0, done0, err0, cmd_ready}); end
    n_chk++; if ({cs1, re1, we1, a1, dout1, rsp_valid1, rsp_data1, busy1, done1, err1, cmd_ready1} !== 25'd0) begin
      n_fail++; $display("FAIL reset_outputs_dut1: got %h want 0", {cs1, re1, we1, a1, dout1, rsp_valid1, rsp_data1, busy1, done1, err1, cmd_ready1}); end
    rst = 1'b0;
    repeat (3) step();
    n_chk++; if ({cs0, busy0, cmd_ready} !== 3'b000) begin
      n_fail++; $display("FAIL idle_after_reset: got %b want 000", {cs0, busy0, cmd_ready}); end
  endtask

  task automatic test_init_default();
    int k;
    clear_log();
    start0 = 1'b1; step(); start0 = 1'b0;
    n_chk++; if ({cs0, re0, we0, a0, dout0, busy0} !== {4'b1000, 8'h13, 1'b1}) begin
      n_fail++; $display("FAIL icw1_setup: got %h want %h", {cs0, re0, we0, a0, dout0, busy0}, {4'b1000, 8'h13, 1'b1}); end
    step();
    n_chk++; if ({cs0, re0, we0, a0, dout0} !== {4'b1010, 8'h13}) begin
      n_fail++; $display("FAIL icw1_strobe: got %h want %h", {cs0, re0, we0, a0, dout0}, {4'b1010, 8'h13}); end
    step();
    n_chk++; if ({cs0, re0, we0, a0, dout0, busy0} !== {12'h000, 1'b1}) begin
      n_fail++; $display("FAIL icw1_recover: got %h want %h", {cs0, re0, we0, a0, dout0, busy0}, {12'h000, 1'b1}); end
    for (k = 4; k < 13; k++) step();
    n_chk++; if (done0 !== 1'b0) begin n_fail++; $display("FAIL init_done_c12: got %b want 0", done0); end
    step();
    n_chk++; if ({done0, busy0, cmd_ready} !== 3'b101) begin
      n_fail++; $display("FAIL init_done_c13: got %b want 101", {done0, busy0, cmd_ready}); end
    n_chk++; if (wlog0.size() != 4) begin n_fail++; $display("FAIL default_write_count: got %0d want 4", wlog0.size()); end
    for (int i = 0; i < 4; i++) begin
      n_chk++; if (wlog0[i] !== exp_def[i]) begin n_fail++; $display("FAIL default_write_%0d: got %h want %h", i, wlog0[i], exp_def[i]); end
    end
  endtask

  task automatic test_init_cascade();
    wlog1.delete();
    start1 = 1'b1; step(); start1 = 1'b0;
    for (int k = 2; k < 16; k++) step();
    n_chk++; if (done1 !== 1'b0) begin n_fail++; $display("FAIL cascade_done_c15: got %b want 0", done1); end
    step();
    n_chk++; if ({done1, busy1, err1} !== 3'b100) begin n_fail++; $display("FAIL cascade_done_c16: got %b want 100", {done1, busy1, err1}); end
    n_chk++; if (wlog1.size() != 5) begin n_fail++; $display("FAIL cascade_write_count: got %0d want 5", wlog1.size()); end
    for (int i = 0; i < 5; i++) begin
      n_chk++; if (wlog1[i] !== exp_cas[i]) begin n_fail++; $display("FAIL cascade_write_%0d: got %h want %h", i, wlog1[i], exp_cas[i]); end
    end
  endtask

  task automatic test_cmd();
    clear_log();
    cmd_valid = 1'b1; cmd_read = 1'b0; cmd_addr = 1'b0; cmd_data = 8'h0B;
    #1;
    n_chk++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL cmd_ready_idle: got %b want 1", cmd_ready); end
    step(); cmd_valid = 1'b0;
    n_chk++; if ({cmd_ready, busy0, cs0} !== 3'b011) begin n_fail++; $display("FAIL cmd_write_setup: got %b want 011", {cmd_ready, busy0, cs0}); end
    step();
    n_chk++; if ({we0, re0, a0, dout0} !== {3'b100, 8'h0B}) begin
      n_fail++; $display("FAIL cmd_write_strobe: got %h want %h", {we0, re0, a0, dout0}, {3'b100, 8'h0B}); end
    step(); step();
    n_chk++; if ({busy0, cmd_ready} !== 2'b01) begin n_fail++; $display("FAIL cmd_write_end: got %b want 01", {busy0, cmd_ready}); end
    n_chk++; if (wlog0.size() != 1 || wlog0[0] !== 9'h00B) begin n_fail++; $display("FAIL cmd_write_log: got %h want 00B", wlog0[0]); end
    pic_rd = 8'h5A;
    cmd_valid = 1'b1; cmd_read = 1'b1; cmd_addr = 1'b0; cmd_data = 8'hAA;
    step(); cmd_valid = 1'b0;
    n_chk++; if ({rsp_valid, dout0} !== 9'h000) begin n_fail++; $display("FAIL read_setup: got %h want 000", {rsp_valid, dout0}); end
    step();
    n_chk++; if ({re0, we0, a0, dout0, rsp_valid} !== {3'b100, 8'h00, 1'b0}) begin
      n_fail++; $display("FAIL read_strobe: got %h want %h", {re0, we0, a0, dout0, rsp_valid}, {3'b100, 8'h00, 1'b0}); end
    step();
    n_chk++; if ({rsp_valid, rsp_data} !== {1'b1, 8'h5A}) begin
      n_fail++; $display("FAIL read_rsp_k3: got %h want 15A", {rsp_valid, rsp_data}); end
    step();
    n_chk++; if ({rsp_valid, rsp_data} !== {1'b0, 8'h5A}) begin
      n_fail++; $display("FAIL read_rsp_hold: got %h want 05A", {rsp_valid, rsp_data}); end
    pic_rd = 8'hC3;
    cmd_valid = 1'b1; cmd_read = 1'b1; cmd_addr = 1'b1;
    step(); cmd_valid = 1'b0;
    step();
    n_chk++; if ({re0, a0} !== 2'b11) begin n_fail++; $display("FAIL imr_read_strobe: got %b want 11", {re0, a0}); end
    step();
    n_chk++; if ({rsp_valid, rsp_data} !== {1'b1, 8'hC3}) begin
      n_fail++; $display("FAIL imr_read_rsp: got %h want 1C3", {rsp_valid, rsp_data}); end
    step();
  endtask

  task automatic test_start_vs_cmd();
    int k;
    clear_log();
    start0 = 1'b1; cmd_valid = 1'b1; cmd_read = 1'b0; cmd_addr = 1'b1; cmd_data = 8'h55;
    #1;
    n_chk++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL start_beats_cmd_ready: got %b want 0", cmd_ready); end
    step(); start0 = 1'b0; cmd_valid = 1'b0;
    n_chk++; if ({done0, cs0, a0, dout0} !== {3'b010, 8'h13}) begin
      n_fail++; $display("FAIL restart_setup: got %h want %h", {done0, cs0, a0, dout0}, {3'b010, 8'h13}); end
    for (k = 1; k < 30 && done0 !== 1'b1; k++) step();
    n_chk++; if (k != 13) begin n_fail++; $display("FAIL restart_done_cycle: got %0d want 13", k); end
    n_chk++; if (wlog0.size() != 4 || wlog0[0] !== 9'h013) begin
      n_fail++; $display("FAIL restart_writes: got %0d words first %h want 4 words first 013", wlog0.size(), wlog0[0]); end
  endtask

  task automatic test_wait_states();
    int k;
    clear_log();
    unstable = 1'b0; stall_idx = 1; stall_need = 4;
    start0 = 1'b1; step(); start0 = 1'b0;
    for (k = 1; k < 9; k++) step();
    n_chk++; if ({we0, a0, dout0} !== {2'b11, 8'h08}) begin
      n_fail++; $display("FAIL icw2_wait_hold: got %h want %h", {we0, a0, dout0}, {2'b11, 8'h08}); end
    for (; k < 40 && done0 !== 1'b1; k++) step();
    n_chk++; if (k != 17) begin n_fail++; $display("FAIL wait_done_cycle: got %0d want 17", k); end
    n_chk++; if (wlen0.size() != 4 || wlen0[0] != 1 || wlen0[1] != 5) begin
      n_fail++; $display("FAIL icw2_strobe_len: got %0d want 5", wlen0[1]); end
    n_chk++; if (unstable !== 1'b0) begin n_fail++; $display("FAIL strobe_stability: got %b want 0", unstable); end
    n_chk++; if (wlog0[1] !== 9'h108 || wlog0[3] !== 9'h1FF) begin
      n_fail++; $display("FAIL wait_writes: got %h %h want 108 1FF", wlog0[1], wlog0[3]); end
    stall_idx = -1;
  endtask

  task automatic test_ack_at_timeout();
    int k;
    clear_log();
    stall_idx = 0; stall_need = 14;
    start0 = 1'b1; step(); start0 = 1'b0;
    for (k = 1; k < 60 && done0 !== 1'b1; k++) step();
    n_chk++; if ({k[7:0], err0} !== {8'd27, 1'b0}) begin
      n_fail++; $display("FAIL ack_at_limit: got cycle %0d error %b want 27 0", k, err0); end
    n_chk++; if (wlen0.size() == 0 || wlen0[0] != 15) begin
      n_fail++; $display("FAIL ack_at_limit_len: got %0d want 15", (wlen0.size() == 0) ? 0 : wlen0[0]); end
    stall_idx = -1;
  endtask

  task automatic test_timeout();
    int n_strobe, k;
    clear_log();
    ack_en = 1'b0; n_strobe = 0;
    start0 = 1'b1; step(); start0 = 1'b0;
    for (k = 0; k < 40; k++) begin
      step();
      if (we0) n_strobe++;
      else if (n_strobe > 0) break;
    end
    n_chk++; if (n_strobe != 15) begin n_fail++; $display("FAIL timeout_strobe_len: got %0d want 15", n_strobe); end
    n_chk++; if ({cs0, we0, err0} !== 3'b000) begin n_fail++; $display("FAIL timeout_recover: got %b want 000", {cs0, we0, err0}); end
    step();
    n_chk++; if ({err0, done0, busy0} !== 3'b100) begin n_fail++; $display("FAIL timeout_flags: got %b want 100", {err0, done0, busy0}); end
    step(); step();
    n_chk++; if ({cs0, err0, cmd_ready} !== 3'b010) begin n_fail++; $display("FAIL timeout_abort: got %b want 010", {cs0, err0, cmd_ready}); end
    ack_en = 1'b1;
    start0 = 1'b1; step(); start0 = 1'b0;
    n_chk++; if ({err0, cs0} !== 2'b01) begin n_fail++; $display("FAIL start_clears_error: got %b want 01", {err0, cs0}); end
    for (k = 1; k < 30 && done0 !== 1'b1; k++) step();
    n_chk++; if (done0 !== 1'b1) begin n_fail++; $display("FAIL reinit_after_error: got %b want 1", done0); end
  endtask

  task automatic test_reset_mid();
    int k, n_cs;
    clear_log();
    stall_idx = 1; stall_need = 4;
    start0 = 1'b1; step(); start0 = 1'b0;
    for (k = 0; k < 20 && !(we0 && a0 && dout0 == 8'h08); k++) step();
    n_chk++; if ({we0, a0, dout0} !== {2'b11, 8'h08}) begin
      n_fail++; $display("FAIL reach_icw2_strobe: got %h want %h", {we0, a0, dout0}, {2'b11, 8'h08}); end
    #2 rst = 1'b1;
    #1;
    n_chk++; if ({cs0, re0, we0, a0, dout0, rsp_valid, rsp_data, busy0, done0, err0, cmd_ready} !== 25'd0) begin
      n_fail++; $display("FAIL async_reset_outputs: got %h want 0", {cs0, re0, we0, a0, dout0, rsp_valid, rsp_data, busy0, done0, err0, cmd_ready}); end
    step(); rst = 1'b0;
    n_cs = 0;
    for (k = 0; k < 10; k++) begin
      step();
      if (cs0) n_cs++;
    end
    n_chk++; if (n_cs != 0) begin n_fail++; $display("FAIL no_resume_after_reset: got %0d cs cycles want 0", n_cs); end
    n_chk++; if ({cmd_ready, done0, busy0} !== 3'b000) begin
      n_fail++; $display("FAIL post_reset_idle: got %b want 000", {cmd_ready, done0, busy0}); end
    stall_idx = -1;
  endtask

  initial begin
    test_reset();
    test_init_default();
    test_init_cascade();
    test_cmd();
    test_start_vs_cmd();
    test_wait_states();
    test_ack_at_timeout();
    test_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
